// File: rtl/ram_arb_slave.sv
// Multi-master RAM slave: round-robin registered grants, 1-cycle registered reads, sticky range-error IRQ.
// Optional build macro RAM_CLEAR_EN: zero the whole RAM word by word after every reset.
module ram_arb_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int NUM_M  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_M-1:0]          M_req,
  input  logic [NUM_M-1:0]          M_wr,
  input  logic [NUM_M*ADDR_W-1:0]   M_address,
  input  logic [NUM_M*DATA_W-1:0]   M_dout,
  input  logic                      int_clr,
  output logic [NUM_M-1:0]          M_grant,
  output logic [DATA_W-1:0]         M_din,
  output logic                      m_interrupt
);
  localparam int OW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable and nothing aliases.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, CLEAR} state_e;
`ifdef RAM_CLEAR_EN
  localparam state_e START = CLEAR;
`else
  localparam state_e START = IDLE;
`endif

  state_e                           state_q, state_d;
  logic [OW-1:0]                    owner_q, owner_d, rr_q, rr_d, sel;
  logic [NUM_M-1:0]                 grant_q, grant_d;
  logic [DATA_W-1:0]                din_q, din_d;
  logic                             irq_q, irq_d;
  logic [DATA_W-1:0]                mem [DEPTH];
  logic [NUM_M-1:0][ADDR_W-1:0]     addr_v;
  logic [NUM_M-1:0][DATA_W-1:0]     dout_v;
  logic [ADDR_W-1:0]                own_addr;
  logic                             in_range, access;
`ifdef RAM_CLEAR_EN
  logic [MW-1:0]                    clr_q, clr_d;
`endif

  assign addr_v   = M_address;
  assign dout_v   = M_dout;
  assign own_addr = addr_v[owner_q];
  assign in_range = {1'b0, own_addr} < DEPTH_L;

  // Scan from the highest offset down so the requester closest to rr wins.
  always_comb begin
    sel = rr_q;
    for (int i = NUM_M-1; i >= 0; i--) begin
      if (M_req[OW'((int'(rr_q) + i) % NUM_M)]) sel = OW'((int'(rr_q) + i) % NUM_M);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|M_req) begin
          owner_d = sel;
          grant_d = NUM_M'(1) << sel;
          state_d = BUSY;
        end else begin
          grant_d = '0;
        end
      end
      BUSY: begin
        if (M_req[owner_q]) begin
          access = grant_q[owner_q];
        end else begin
          grant_d = '0;
          rr_d    = OW'((int'(owner_q) + 1) % NUM_M);
          state_d = IDLE;
        end
      end
`ifdef RAM_CLEAR_EN
      CLEAR: begin
        grant_d = '0;
        if (clr_q == MW'(DEPTH-1)) state_d = IDLE;
      end
`endif
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef RAM_CLEAR_EN
  assign clr_d = (state_q == CLEAR) ? clr_q + 1'b1 : '0;
`endif

  // A new error on the same edge as int_clr keeps the flag set.
  always_comb begin
    din_d = '0;
    irq_d = irq_q;
    if (int_clr) irq_d = 1'b0;
    if (access && !in_range) irq_d = 1'b1;
    if (access && !M_wr[owner_q] && in_range) din_d = mem[own_addr[MW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= START;
      owner_q <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      din_q   <= '0;
      irq_q   <= 1'b0;
`ifdef RAM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      din_q   <= din_d;
      irq_q   <= irq_d;
`ifdef RAM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // Storage has no reset; reset only blocks the write on its edge.
  always_ff @(posedge clk) begin
    if (reset_n && access && M_wr[owner_q] && in_range)
      mem[own_addr[MW-1:0]] <= dout_v[owner_q];
`ifdef RAM_CLEAR_EN
    else if (reset_n && state_q == CLEAR)
      mem[clr_q] <= '0;
`endif
  end

  assign M_grant     = grant_q;
  assign M_din       = din_q;
  assign m_interrupt = irq_q;
endmodule

// File: tb/tb_ram_arb_slave.sv
// Directed bench for ram_arb_slave: expected read data queued at drive time, checked after each edge.
module tb_ram_arb_slave;
  localparam int DW = 32, AW = 8, DEPTH = 64, NM = 2;

  logic              clk = 1'b0, reset_n = 1'b0, int_clr = 1'b0;
  logic [NM-1:0]     M_req = '0, M_wr = '0, M_grant;
  logic [NM*AW-1:0]  M_address = '0;
  logic [NM*DW-1:0]  M_dout = '0;
  logic [DW-1:0]     M_din;
  logic              m_interrupt;
  logic [DW-1:0]     mm [DEPTH];
  logic [DW-1:0]     exp_q [$];
  int                n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  ram_arb_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_M(NM)) dut (
    .clk(clk), .reset_n(reset_n), .M_req(M_req), .M_wr(M_wr), .M_address(M_address),
    .M_dout(M_dout), .int_clr(int_clr), .M_grant(M_grant), .M_din(M_din),
    .m_interrupt(m_interrupt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic req, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    M_req[m] = req;
    M_wr[m]  = wr;
    M_address[m*AW +: AW] = a;
    M_dout[m*DW +: DW]    = d;
  endtask

  task automatic cyc(input string tag, input logic [NM-1:0] eg, input logic [DW-1:0] ed);
    exp_q.push_back(ed);
    tick();
    chk({tag, ":grant"}, 64'(M_grant), 64'(eg));
    chk({tag, ":din"}, 64'(M_din), 64'(exp_q.pop_front()));
  endtask

  // One access by the current owner m; the model gives the read value.
  task automatic acc(input int m, input logic wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input string tag);
    logic [DW-1:0] ed;
    ed = '0;
    set_m(m, 1'b1, wr, a, d);
    if (a < DEPTH) begin
      if (wr) mm[a[5:0]] = d;
      else    ed = mm[a[5:0]];
    end
    cyc(tag, NM'(1) << m, ed);
  endtask

  task automatic finish_reset();
    reset_n = 1'b1;
    M_req   = '0;
`ifdef RAM_CLEAR_EN
    repeat (DEPTH) tick();
    foreach (mm[i]) mm[i] = '0;
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst:grant", 64'(M_grant), 64'h0);
    chk("rst:din", 64'(M_din), 64'h0);
    chk("rst:irq", 64'(m_interrupt), 64'h0);

`ifdef RAM_CLEAR_EN
    reset_n = 1'b1;
    set_m(0, 1'b1, 1'b0, 8'd0, '0);
    for (int i = 0; i < DEPTH; i++) cyc("clr_nogrant", 2'b00, '0);
    cyc("clr_grant", 2'b01, '0);
    foreach (mm[i]) mm[i] = '0;
    for (int a = 0; a < DEPTH; a++) acc(0, 1'b0, AW'(a), '0, "clr_read");
    set_m(0, 1'b0, 1'b0, 8'd0, '0);
    cyc("clr_rel", 2'b00, '0);
`else
    finish_reset();
`endif

    // Idle: nothing requested
    for (int i = 0; i < 3; i++) cyc("idle", 2'b00, '0);

    // Single master writes then reads back
    set_m(0, 1'b1, 1'b1, 8'd0, 32'h5);
    cyc("t1_grant", 2'b01, '0);
    acc(0, 1'b1, 8'd0, 32'h05, "t1_w0");
    acc(0, 1'b1, 8'd1, 32'h00, "t1_w1");
    acc(0, 1'b1, 8'd2, 32'h07, "t1_w2");
    acc(0, 1'b1, 8'd3, 32'hFF, "t1_w3");
    for (int a = 0; a < 4; a++) acc(0, 1'b0, AW'(a), '0, "t1_rd");
    acc(0, 1'b1, 8'h0B, 32'hB0B0, "t1_w0b");
    acc(0, 1'b1, 8'd5, 32'h55, "t1_w5");
    acc(0, 1'b1, 8'd63, 32'h3F3F, "t1_w63");
    acc(0, 1'b0, 8'd63, '0, "t1_r63");
    chk("t1_irq", 64'(m_interrupt), 64'h0);

    // Out-of-range accesses and the sticky interrupt
    acc(0, 1'b1, 8'h4B, 32'h1234, "t3_woor");
    chk("t3_irq_set", 64'(m_interrupt), 64'h1);
    acc(0, 1'b0, 8'h0B, '0, "t3_r0b");
    acc(0, 1'b0, 8'h4B, '0, "t3_roor");
    acc(0, 1'b0, 8'd64, '0, "t3_r64");
    chk("t3_irq_sticky", 64'(m_interrupt), 64'h1);
    int_clr = 1'b1;
    acc(0, 1'b0, 8'd2, '0, "t3_clr");
    chk("t3_irq_clr", 64'(m_interrupt), 64'h0);
    acc(0, 1'b0, 8'h80, '0, "t3_clr_err");
    chk("t3_irq_setwins", 64'(m_interrupt), 64'h1);
    int_clr = 1'b0;

    // Reset in the middle of a write burst
    set_m(0, 1'b1, 1'b1, 8'd5, 32'hDEAD);
    reset_n = 1'b0;
    tick();
    chk("t4:grant", 64'(M_grant), 64'h0);
    chk("t4:din", 64'(M_din), 64'h0);
    chk("t4:irq", 64'(m_interrupt), 64'h0);
    finish_reset();
    set_m(0, 1'b1, 1'b0, 8'd5, '0);
    cyc("t4_grant", 2'b01, '0);
    acc(0, 1'b0, 8'd5, '0, "t4_r5");
    set_m(0, 1'b0, 1'b0, 8'd0, '0);
    cyc("t4_rel", 2'b00, '0);

    // Contention from a fresh reset
    reset_n = 1'b0;
    tick();
    finish_reset();
    set_m(0, 1'b1, 1'b0, 8'd0, '0);
    set_m(1, 1'b1, 1'b0, 8'd1, '0);
    cyc("t2_g0", 2'b01, '0);
    acc(0, 1'b0, 8'd0, '0, "t2_m0r");
    acc(0, 1'b0, 8'd1, '0, "t2_m0r");
    set_m(0, 1'b0, 1'b0, 8'd0, '0);
    cyc("t2_gap", 2'b00, '0);
    cyc("t2_g1", 2'b10, '0);
    set_m(0, 1'b1, 1'b1, 8'd1, 32'h999);
    acc(1, 1'b0, 8'd1, '0, "t2_m1r");
    acc(1, 1'b0, 8'd1, '0, "t2_nonowner");
    set_m(0, 1'b1, 1'b0, 8'd1, '0);
    set_m(1, 1'b0, 1'b0, 8'd0, '0);
    cyc("t2_gap2", 2'b00, '0);
    cyc("t2_rr", 2'b01, '0);
    set_m(0, 1'b0, 1'b0, 8'd0, '0);
    cyc("t2_rel", 2'b00, '0);
    cyc("t2_idle", 2'b00, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
